// File: rtl/estagio_writeback.sv
// Write-back stage: MEM/WB pipeline register, load formatting, register bank
// write/link ports, forwarding copy for EX and retired-instruction counter.
module estagio_writeback #(
    parameter int LARGURA         = 32,
    parameter int INCREMENTO_LINK = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hazard,
    input  logic               flush,
    input  logic               mem_valido,
    input  logic               mem_regEscrita,
    input  logic               mem_link,
    input  logic               mem_memParaReg,
    input  logic [2:0]         mem_tipoLoad,
    input  logic [4:0]         mem_destino,
    input  logic [LARGURA-1:0] mem_resultadoUla,
    input  logic [LARGURA-1:0] mem_dadosMemoria,
    input  logic [LARGURA-1:0] mem_pc,
    output logic               registradorEscrita,
    output logic [LARGURA-1:0] enderecoEscrita,
    output logic [LARGURA-1:0] dadosEscrita,
    output logic               link,
    output logic [LARGURA-1:0] dadosLink,
    output logic               fwd_valido,
    output logic [4:0]         fwd_destino,
    output logic [LARGURA-1:0] fwd_dados,
    output logic               erroEndereco,
    output logic [LARGURA-1:0] instrucoesRetiradas
);

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LHU = 3'b010;
    localparam logic [2:0] LOAD_LB  = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;

    logic               wb_valido;
    logic               wb_regEscrita;
    logic               wb_link;
    logic               wb_memParaReg;
    logic [2:0]         wb_tipoLoad;
    logic [4:0]         wb_destino;
    logic [LARGURA-1:0] wb_resultadoUla;
    logic [LARGURA-1:0] wb_dadosMemoria;
    logic [LARGURA-1:0] wb_pc;
    logic [LARGURA-1:0] contador;

    logic [1:0]         offset;
    logic [15:0]        meia;
    logic [7:0]         byte_sel;
    logic [31:0]        carga_formatada;
    logic               desalinhado;

    // MEM/WB register: reset/flush insert a bubble, hazard holds, else capture
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wb_valido       <= 1'b0;
            wb_regEscrita   <= 1'b0;
            wb_link         <= 1'b0;
            wb_memParaReg   <= 1'b0;
            wb_tipoLoad     <= '0;
            wb_destino      <= '0;
            wb_resultadoUla <= '0;
            wb_dadosMemoria <= '0;
            wb_pc           <= '0;
        end else if (!hazard) begin
            wb_valido       <= mem_valido;
            wb_regEscrita   <= mem_regEscrita;
            wb_link         <= mem_link;
            wb_memParaReg   <= mem_memParaReg;
            wb_tipoLoad     <= mem_tipoLoad;
            wb_destino      <= mem_destino;
            wb_resultadoUla <= mem_resultadoUla;
            wb_dadosMemoria <= mem_dadosMemoria;
            wb_pc           <= mem_pc;
        end
    end

    // Retired-instruction counter; the instruction leaving WB counts even if
    // a flush replaces it, but not while hazard keeps it in place
    always_ff @(posedge clock) begin
        if (reset) begin
            contador <= '0;
        end else if (wb_valido && !hazard) begin
            contador <= contador + 1'b1;
        end
    end

    assign offset   = wb_resultadoUla[1:0];
    assign meia     = offset[1] ? wb_dadosMemoria[15:0] : wb_dadosMemoria[31:16];
    assign byte_sel = wb_dadosMemoria[31 - 8*offset -: 8];

    // Big-endian load formatter; unknown load types behave as LW
    always_comb begin
        carga_formatada = wb_dadosMemoria;
        desalinhado     = (offset != 2'b00);
        case (wb_tipoLoad)
            LOAD_LH: begin
                carga_formatada = {{16{meia[15]}}, meia};
                desalinhado     = offset[0];
            end
            LOAD_LHU: begin
                carga_formatada = {16'h0000, meia};
                desalinhado     = offset[0];
            end
            LOAD_LB: begin
                carga_formatada = {{24{byte_sel[7]}}, byte_sel};
                desalinhado     = 1'b0;
            end
            LOAD_LBU: begin
                carga_formatada = {24'h000000, byte_sel};
                desalinhado     = 1'b0;
            end
            default: begin
                carga_formatada = wb_dadosMemoria;
                desalinhado     = (offset != 2'b00);
            end
        endcase
    end

    // Write-port, link-port and forwarding outputs straight from MEM/WB
    always_comb begin
        erroEndereco       = wb_valido & wb_memParaReg & desalinhado;
        link               = wb_valido & wb_link;
        registradorEscrita = wb_valido & wb_regEscrita & (wb_destino != 5'd0)
                             & ~wb_link & ~erroEndereco;
        enderecoEscrita    = {{(LARGURA-5){1'b0}}, wb_destino};
        dadosEscrita       = wb_memParaReg ? carga_formatada : wb_resultadoUla;
        // bubbles show 0 on the link bus instead of a stale 0 + offset
        dadosLink          = wb_valido ? (wb_pc + LARGURA'(INCREMENTO_LINK)) : '0;
        fwd_valido         = registradorEscrita | link;
        fwd_destino        = link ? 5'd31 : wb_destino;
        fwd_dados          = link ? dadosLink : dadosEscrita;
        instrucoesRetiradas = contador;
    end

endmodule
